// File: rtl/res_axis_out.sv
// Double-buffered result collector: the execution controller fills one bank while the
// other drains to M_AXIS in address order, one word per cycle, with full backpressure.
module res_axis_out #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 32
) (
  input  logic          AXIS_ACLK,
  input  logic          AXIS_ARESETN,
  input  logic          outr,
  input  logic [AW-1:0] oa,
  input  logic [DW-1:0] result,
  input  logic          commit,
  input  logic          commit_last,
  output logic          out_busy,
  output logic          idle,
  output logic          M_AXIS_TVALID,
  output logic [DW-1:0] M_AXIS_TDATA,
  output logic          M_AXIS_TLAST,
  input  logic          M_AXIS_TREADY
);

  logic [DW-1:0] mem [2][DEPTH];
  logic [1:0]    full, full_nxt;
  logic [1:0]    lastf, lastf_nxt;
  logic          wr_bank;
  logic          rd_bank;
  logic [AW-1:0] rd_ptr;

  logic wr_ok;
  logic do_commit;
  logic load;
  logic rd_end;

  assign wr_ok     = ~full[wr_bank];
  assign do_commit = commit & wr_ok;
  assign load      = full[rd_bank] & (~M_AXIS_TVALID | M_AXIS_TREADY);
  assign rd_end    = (rd_ptr == AW'(DEPTH - 1));

  assign out_busy = full[wr_bank];
  assign idle     = ~full[0] & ~full[1] & ~M_AXIS_TVALID;

  // Storage is not reset; a bank's contents are only visible once committed.
  always_ff @(posedge AXIS_ACLK) begin
    if (outr & wr_ok)
      mem[wr_bank][oa] <= result;
  end

  // Commit and drain-release can hit in one cycle; they always address different banks.
  always_comb begin
    full_nxt  = full;
    lastf_nxt = lastf;
    if (do_commit) begin
      full_nxt[wr_bank]  = 1'b1;
      lastf_nxt[wr_bank] = commit_last;
    end
    if (load & rd_end)
      full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      full    <= '0;
      lastf   <= '0;
      wr_bank <= 1'b0;
    end else begin
      full  <= full_nxt;
      lastf <= lastf_nxt;
      if (do_commit)
        wr_bank <= ~wr_bank;
    end
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      rd_bank       <= 1'b0;
      rd_ptr        <= '0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TLAST  <= 1'b0;
    end else if (load) begin
      M_AXIS_TDATA  <= mem[rd_bank][rd_ptr];
      M_AXIS_TVALID <= 1'b1;
      M_AXIS_TLAST  <= lastf[rd_bank] & rd_end;
      if (rd_end) begin
        rd_ptr  <= '0;
        rd_bank <= ~rd_bank;
      end else begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end else if (M_AXIS_TVALID & M_AXIS_TREADY) begin
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TLAST  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_res_axis_out.sv
// Self-checking bench for res_axis_out: random data and backpressure, scoreboarded against
// a queue of expected beats built from committed banks.
module tb_res_axis_out;

  logic        clk;
  logic        rst_n;
  logic        outr;
  logic [3:0]  oa;
  logic [31:0] result;
  logic        commit;
  logic        commit_last;
  logic        out_busy;
  logic        idle;
  logic        tvalid;
  logic [31:0] tdata;
  logic        tlast;
  logic        tready;

  res_axis_out #(.DEPTH(16), .AW(4), .DW(32)) dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESETN  (rst_n),
    .outr          (outr),
    .oa            (oa),
    .result        (result),
    .commit        (commit),
    .commit_last   (commit_last),
    .out_busy      (out_busy),
    .idle          (idle),
    .M_AXIS_TVALID (tvalid),
    .M_AXIS_TDATA  (tdata),
    .M_AXIS_TLAST  (tlast),
    .M_AXIS_TREADY (tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } beat_t;

  beat_t exp_q[$];
  int    n_chk  = 0;
  int    n_fail = 0;
  int    beats  = 0;
  int    rdy_mode = 0;   // 0: hold low, 1: hold high, 2: random

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 2) tready = 1'($urandom_range(0, 1));
      else               tready = (rdy_mode == 1);
    end
  end

  // Sampled on the falling edge: a beat seen with valid & ready is taken on the next rise.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_d;
  logic        prev_l;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", tvalid, 1'b1);
          chk("hold_data", tdata, prev_d);
          chk("hold_last", tlast, prev_l);
        end
        if (exp_q.size() == 0) begin
          chk("no_beat", tvalid, 1'b0);
        end else if (tvalid && tready) begin
          beat_t b;
          b = exp_q.pop_front();
          chk("beat_data", tdata, b.d);
          chk("beat_last", tlast, b.l);
          beats++;
        end
        prev_stall = tvalid & ~tready;
        prev_d     = tdata;
        prev_l     = tlast;
      end
    end
  end

  task automatic set_rdy(input int m);
    @(posedge clk);
    rdy_mode = m;
    #1;
  endtask

  task automatic write_bank(input bit last, input bit same, input bit seq);
    logic [31:0] buf_w [16];
    int unsigned n;
    n = 0;
    while (out_busy && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (out_busy) chk("busy_timeout", out_busy, 1'b0);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      buf_w[i] = seq ? 32'(32'h100 + i) : $urandom;
      outr   = 1'b1;
      oa     = 4'(i);
      result = buf_w[i];
      if (same && i == 15) begin
        commit      = 1'b1;
        commit_last = last;
        for (int k = 0; k < 16; k++) exp_q.push_back('{buf_w[k], last && k == 15});
      end
    end
    @(posedge clk);
    #1;
    outr = 1'b0;
    if (!same) begin
      commit      = 1'b1;
      commit_last = last;
      for (int k = 0; k < 16; k++) exp_q.push_back('{buf_w[k], last && k == 15});
      @(posedge clk);
      #1;
    end
    commit      = 1'b0;
    commit_last = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int b0;
    rst_n = 1'b0; outr = 1'b0; oa = '0; result = '0; commit = 1'b0; commit_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", tvalid, 1'b0);
    chk("rst_tlast", tlast, 1'b0);
    chk("rst_tdata", tdata, 32'h0);
    chk("rst_busy", out_busy, 1'b0);
    chk("rst_idle", idle, 1'b1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single bank, sequential data, latency and contiguity
    set_rdy(1);
    write_bank(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("lat_edge_n", tvalid, 1'b0);
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      chk("t1_contig", tvalid, 1'b1);
    end
    @(negedge clk);
    chk("t1_end", tvalid, 1'b0);
    chk("t1_idle", idle, 1'b1);
    drain();

    // 2: two banks back-to-back, 32 contiguous beats
    set_rdy(0);
    write_bank(1'b0, 1'b0, 1'b0);
    write_bank(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2_busy_full", out_busy, 1'b1);
    set_rdy(1);
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      chk("t2_contig", tvalid, 1'b1);
      if (j == 14) chk("t2_busy_held", out_busy, 1'b1);
      if (j == 15) chk("t2_busy_free", out_busy, 1'b0);
    end
    drain();

    // 3: random backpressure within a bank
    set_rdy(2);
    write_bank(1'b1, 1'b0, 1'b0);
    drain();

    // 4: writes and commit to a full bank are ignored
    set_rdy(0);
    write_bank(1'b0, 1'b0, 1'b0);
    write_bank(1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    outr = 1'b1; oa = 4'd3; result = 32'hDEAD_BEEF; commit = 1'b1; commit_last = 1'b1;
    @(posedge clk);
    #1;
    outr = 1'b0; commit = 1'b0; commit_last = 1'b0;
    @(negedge clk);
    chk("t4_busy", out_busy, 1'b1);
    chk("t4_not_idle", idle, 1'b0);
    set_rdy(1);
    drain();
    chk("t4_idle", idle, 1'b1);

    // 5: reset mid-stream
    write_bank(1'b1, 1'b0, 1'b0);
    b0 = beats;
    for (int n = 0; n < 200 && beats - b0 < 7; n++) @(negedge clk);
    chk("t5_reached", (beats - b0 >= 7), 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_tvalid", tvalid, 1'b0);
    chk("t5_tlast", tlast, 1'b0);
    chk("t5_busy", out_busy, 1'b0);
    chk("t5_idle", idle, 1'b1);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("t5_quiet", tvalid, 1'b0);
    chk("t5_idle_after", idle, 1'b1);

    // 6: last write and commit in the same cycle
    write_bank(1'b1, 1'b1, 1'b0);
    drain();

    // random multi-bank traffic
    set_rdy(2);
    for (int r = 0; r < 8; r++)
      write_bank(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    drain();
    chk("end_idle", idle, 1'b1);
    chk("end_busy", out_busy, 1'b0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
